// File: rtl/csa_pkg.sv
// Shared constants and geometry helpers for the pipelined carry-select adder.
package csa_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int MIN_BLK    = 1;
    localparam int MIN_STAGES = 1;

    function automatic int slices_per_stage(input int width, input int blk, input int stages);
        return width / (blk * stages);
    endfunction

    // Legal geometry: WIDTH splits evenly into STAGES groups of whole slices.
    function automatic bit geometry_ok(input int width, input int blk, input int stages);
        if (blk < MIN_BLK || stages < MIN_STAGES)
            return 1'b0;
        return ((width % (blk * stages)) == 0) && (stages <= (width / blk));
    endfunction

endpackage

// File: rtl/csa_slice.sv
// One BLK-bit carry-select slice: both carry-in outcomes are precomputed and
// the incoming carry only drives the final selects. Purely combinational.
module csa_slice
#(
    parameter int BLK = 4
)
(
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout
);

    logic [BLK-1:0] s0;
    logic [BLK-1:0] s1;
    logic [BLK:0]   c0;
    logic [BLK:0]   c1;

    always_comb begin
        s0    = '0;
        s1    = '0;
        c0    = '0;
        c1    = '0;
        c0[0] = 1'b0;
        c1[0] = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            s0[i]   = a[i] ^ b[i] ^ c0[i];
            c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
            s1[i]   = a[i] ^ b[i] ^ c1[i];
            c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
        end
    end

    assign s    = cin ? s1 : s0;
    assign cout = cin ? c1[BLK] : c0[BLK];

endmodule

// File: rtl/csa_adder_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake.
// Optional build macro CSA_SAT_EN: clamp sum to signed max/min on overflow.
module csa_adder_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLK    = 4,
    parameter int STAGES = 2
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int  SW      = WIDTH / STAGES;
    localparam int  NSL     = slices_per_stage(WIDTH, BLK, STAGES);
    localparam bit  GEOM_OK = geometry_ok(WIDTH, BLK, STAGES);

    if (!GEOM_OK) begin : g_geom_check
        $error("csa_adder_pipe: WIDTH must be a multiple of BLK*STAGES with STAGES <= WIDTH/BLK");
    end

`ifdef CSA_SAT_EN
    function automatic logic [WIDTH-1:0] sat_clamp(input logic [WIDTH-1:0] raw,
                                                   input logic ovf_i,
                                                   input logic a_msb);
        if (!ovf_i)
            return raw;
        return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    // Each stage register holds {not-yet-added A bits, finished sum bits} in
    // acc_p, the remaining inverted-or-plain B bits, and the carry onward.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int BW = WIDTH - k * SW;

        logic             v_src;
        logic [WIDTH-1:0] a_src;
        logic [BW-1:0]    b_src;
        logic             c_src;
        logic             en;
        logic             vld_p;
        logic             cy_p;
        logic [WIDTH-1:0] acc_p;
        logic [SW-1:0]    s_stg;
        logic [WIDTH-1:0] acc_nxt;

        // Stage input: operands from the port, or the previous stage register
        if (k == 0) begin : g_src_in
            assign v_src = in_valid;
            assign a_src = a;
            assign b_src = (sub == OP_ADD) ? b : ~b;
            assign c_src = (sub == OP_SUB) ? 1'b1 : c_in;
        end else begin : g_src_prev
            assign v_src = stg[k-1].vld_p;
            assign a_src = stg[k-1].acc_p;
            assign b_src = stg[k-1].g_mid.bhi_p;
            assign c_src = stg[k-1].cy_p;
        end

        for (genvar j = 0; j < NSL; j++) begin : slc
            logic ci;
            logic co;
            if (j == 0) begin : g_c0
                assign ci = c_src;
            end else begin : g_cn
                assign ci = slc[j-1].co;
            end
            csa_slice #(.BLK(BLK)) u_slice (
                .a    (a_src[k*SW + j*BLK +: BLK]),
                .b    (b_src[j*BLK +: BLK]),
                .cin  (ci),
                .s    (s_stg[j*BLK +: BLK]),
                .cout (co)
            );
        end

        always_comb begin
            acc_nxt             = a_src;
            acc_nxt[k*SW +: SW] = s_stg;
        end

        // Stage register: final stage drives the outputs and is fully reset
        if (k == STAGES - 1) begin : g_last
            logic             ovf_nxt;
            logic             ovf_p;
            logic [WIDTH-1:0] sum_nxt;

            assign en      = !vld_p || out_ready;
            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            assign ovf_nxt = slc[NSL-1].co ^ (s_stg[SW-1] ^ a_src[WIDTH-1] ^ b_src[SW-1]);
`ifdef CSA_SAT_EN
            assign sum_nxt = sat_clamp(acc_nxt, ovf_nxt, a_src[WIDTH-1]);
`else
            assign sum_nxt = acc_nxt;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p <= 1'b0;
                    acc_p <= '0;
                    cy_p  <= 1'b0;
                    ovf_p <= 1'b0;
                end else if (en) begin
                    vld_p <= v_src;
                    acc_p <= sum_nxt;
                    cy_p  <= slc[NSL-1].co;
                    ovf_p <= ovf_nxt;
                end
            end
        end else begin : g_mid
            logic [BW-SW-1:0] bhi_p;

            assign en = !vld_p || stg[k+1].en;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    vld_p <= 1'b0;
                else if (en)
                    vld_p <= v_src;
            end

            always_ff @(posedge clk) begin
                if (en) begin
                    acc_p <= acc_nxt;
                    cy_p  <= slc[NSL-1].co;
                    bhi_p <= b_src[BW-1:SW];
                end
            end
        end
    end

    assign in_ready  = stg[0].en;
    assign out_valid = stg[STAGES-1].vld_p;
    assign sum       = stg[STAGES-1].acc_p;
    assign c_out     = stg[STAGES-1].cy_p;
    assign ovf       = stg[STAGES-1].g_last.ovf_p;

endmodule

// File: tb/tb_csa_adder_pipe.sv
// Scoreboard bench for csa_adder_pipe against a plain-arithmetic add/sub model.
module tb_csa_adder_pipe;

    parameter int WIDTH  = 16;
    parameter int BLK    = 4;
    parameter int STAGES = 2;

    localparam longint MODV = longint'(1) << WIDTH;
    localparam longint SMAX = (MODV / 2) - 1;
    localparam longint SMIN = -(MODV / 2);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c_in = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    csa_adder_pipe #(.WIDTH(WIDTH), .BLK(BLK), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Signed/unsigned integer arithmetic straight from the operation definition.
    function automatic exp_t model(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                                   input logic ci, input logic si);
        exp_t   e;
        longint ua, ub, sa, sbv, sres, ures, cl, t;
        ua  = longint'(ai);
        ub  = longint'(bi);
        sa  = ai[WIDTH-1] ? ua - MODV : ua;
        sbv = bi[WIDTH-1] ? ub - MODV : ub;
        cl  = ci ? 64'sd1 : 64'sd0;
        if (si) begin
            sres    = sa - sbv;
            ures    = ua - ub;
            e.c_out = (ua >= ub);
        end else begin
            sres    = sa + sbv + cl;
            ures    = ua + ub + cl;
            e.c_out = (ures >= MODV);
        end
        e.sum = ures[WIDTH-1:0];
        e.ovf = (sres > SMAX) || (sres < SMIN);
`ifdef CSA_SAT_EN
        if (sres > SMAX) begin
            t     = SMAX;
            e.sum = t[WIDTH-1:0];
        end else if (sres < SMIN) begin
            t     = SMIN;
            e.sum = t[WIDTH-1:0];
        end
`endif
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                         input logic ci, input logic si, input logic ordy, output logic acc);
        @(negedge clk);
        in_valid  = v;
        a         = ai;
        b         = bi;
        c_in      = ci;
        sub       = si;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc)
            sb.push_back(model(ai, bi, ci, si));
    endtask

    task automatic send(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                        input logic ci, input logic si, input logic ordy);
        logic acc;
        int   n;
        n = 0;
        do begin
            drive(1'b1, ai, bi, ci, si, ordy, acc);
            n++;
        end while (!acc && n < 50);
        if (!acc)
            check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++)
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got sum 0x%0h, expected no output", sum);
                end else begin
                    mon_e = sb.pop_front();
                    check("sum", longint'(sum), longint'(mon_e.sum));
                    check("c_out", longint'(c_out), longint'(mon_e.c_out));
                    check("ovf", longint'(ovf), longint'(mon_e.ovf));
                end
            end
        end
    end

    initial begin : stimulus
        logic             acc;
        logic [WIDTH-1:0] ones, smax_v, smin_v, ra, rb;
        logic [WIDTH-1:0] da[8];
        logic [WIDTH-1:0] db[8];
        logic             dc[8];
        logic             ds[8];
        int               sent;

        ones   = '1;
        smax_v = {1'b0, {(WIDTH-1){1'b1}}};
        smin_v = {1'b1, {(WIDTH-1){1'b0}}};

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_sum", longint'(sum), 0);
        check("rst_c_out", longint'(c_out), 0);
        check("rst_ovf", longint'(ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 1);

        drive(1'b1, WIDTH'(16'h1234), WIDTH'(16'h0FFF), 1'b0, 1'b0, 1'b1, acc);
        check("lat_accept", longint'(acc), 1);
        for (int i = 1; i <= STAGES; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            check("latency_out_valid", longint'(out_valid), (i == STAGES) ? 1 : 0);
        end

        da[0] = WIDTH'(16'h1234); db[0] = WIDTH'(16'h0FFF); dc[0] = 1'b0; ds[0] = 1'b0;
        da[1] = ones;             db[1] = '0;               dc[1] = 1'b1; ds[1] = 1'b0;
        da[2] = smax_v;           db[2] = ones;             dc[2] = 1'b0; ds[2] = 1'b1;
        da[3] = WIDTH'(5);        db[3] = WIDTH'(5);        dc[3] = 1'b1; ds[3] = 1'b1;
        da[4] = smin_v;           db[4] = WIDTH'(1);        dc[4] = 1'b0; ds[4] = 1'b1;
        da[5] = smax_v;           db[5] = WIDTH'(1);        dc[5] = 1'b0; ds[5] = 1'b0;
        da[6] = smin_v;           db[6] = smin_v;           dc[6] = 1'b0; ds[6] = 1'b0;
        da[7] = ones;             db[7] = ones;             dc[7] = 1'b1; ds[7] = 1'b0;
        for (int i = 0; i < 8; i++)
            send(da[i], db[i], dc[i], ds[i], 1'b1);
        idle(STAGES + 2);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom()), 1'($urandom()), 1'b1, acc);
            check("throughput_accept", longint'(acc), 1);
        end
        idle(STAGES + 2);

        sent = 0;
        for (int t = 0; t < 40 && sent < 4; t++) begin
            drive(1'b1, WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom()), 1'($urandom()),
                  (t >= 3), acc);
            if (t < 3 && sent >= STAGES)
                check("bp_in_ready", longint'(in_ready), 0);
            if (acc)
                sent++;
        end
        check("bp_sent", sent, 4);
        idle(STAGES + 3);

        drive(1'b1, WIDTH'($urandom()), WIDTH'($urandom()), 1'b0, 1'b0, 1'b0, acc);
        drive(1'b1, WIDTH'($urandom()), WIDTH'($urandom()), 1'b0, 1'b1, 1'b0, acc);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2 * STAGES + 4);
        check("midrst_no_stale", longint'(out_valid), 0);

        for (int i = 0; i < 10000; i++) begin
            ra = WIDTH'($urandom());
            rb = WIDTH'($urandom());
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: ra = ones;
                2: rb = ones;
                default: ;
            endcase
            drive(($urandom_range(0, 3) != 0), ra, rb, 1'($urandom()), 1'($urandom()),
                  ($urandom_range(0, 3) != 0), acc);
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++)
            idle(1);
        check("drain_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
